// File: rtl/accf.sv
// accf: streaming binary32 accumulator.
// Terms enter through a small FIFO. They are summed in arrival order, one per
// cycle, through the combinational addf adder. The packet total is then held
// on the output port until the consumer takes it.
// Optional feature macro: ACCF_OVF_EN adds the sticky out_ovf flag.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. A source holding valid keeps its data
// stable until that edge. The sink may raise or drop ready at any time.
// in_ready depends only on registered FIFO state (!full), and out_valid is a
// register, so neither port has a combinational path from the other side.

// addf: combinational binary32 adder. Rounds to nearest, ties to even, and
// handles subnormals. Any NaN input, or inf + -inf, yields the canonical quiet
// NaN 0x7FC00000. An exact zero sum is +0 unless both operands are -0.
module addf (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, rnd;
    logic [31:0] big;
    logic [30:0] sml;
    logic [7:0]  big_e, sml_e, d;
    logic [23:0] big_m, sml_m;
    logic [26:0] big_ext, sml_ext, sml_sh, mask, norm;
    logic [27:0] sum;
    logic [9:0]  e;
    logic [4:0]  lz, sft;
    logic [31:0] res;

    function automatic logic [4:0] lzc(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    assign a_nan   = (&a[30:23]) & (|a[22:0]);
    assign b_nan   = (&b[30:23]) & (|b[22:0]);
    assign a_inf   = (&a[30:23]) & ~(|a[22:0]);
    assign b_inf   = (&b[30:23]) & ~(|b[22:0]);
    assign eff_sub = a[31] ^ b[31];

    // Order operands by magnitude so the result takes the larger one's sign
    assign swap    = b[30:0] > a[30:0];
    assign big     = swap ? b : a;
    assign sml     = swap ? a[30:0] : b[30:0];

    // Subnormals use exponent 1 with no hidden bit
    assign big_e   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    assign sml_e   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    assign big_m   = {|big[30:23], big[22:0]};
    assign sml_m   = {|sml[30:23], sml[22:0]};
    assign d       = big_e - sml_e;

    // Three extra low bits carry guard, round and sticky
    assign big_ext = {big_m, 3'b000};
    assign sml_ext = {sml_m, 3'b000};
    assign mask    = (27'd1 << d[4:0]) - 27'd1;

    // Align the smaller operand and fold the shifted-out bits into sticky
    always_comb begin
        if (d >= 8'd27) sml_sh = {26'd0, |sml_m};
        else            sml_sh = (sml_ext >> d[4:0]) | {26'd0, |(sml_ext & mask)};
    end

    assign sum = eff_sub ? ({1'b0, big_ext} - {1'b0, sml_sh})
                         : ({1'b0, big_ext} + {1'b0, sml_sh});

    // Normalise (never below exponent 1), then round to nearest even
    always_comb begin
        lz   = lzc(sum[26:0]);
        sft  = 5'd0;
        norm = sum[26:0];
        e    = {2'b00, big_e};
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e    = {2'b00, big_e} + 10'd1;
        end else begin
            if ({5'd0, lz} < ({2'b00, big_e} - 10'd1)) sft = lz;
            else                                       sft = big_e[4:0] - 5'd1;
            norm = sum[26:0] << sft;
            e    = {2'b00, big_e} - {5'd0, sft};
        end
        rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
        // The hidden bit adds one to the exponent field, and a rounding carry
        // ripples into the exponent on its own
        res = (({22'd0, e} - 32'd1) << 23) + {8'd0, norm[26:3]} + {31'd0, rnd};
    end

    // Select special-value, exact-zero, overflow or rounded result
    always_comb begin
        if (a_nan | b_nan | (a_inf & b_inf & eff_sub)) y = 32'h7FC0_0000;
        else if (a_inf)                               y = a;
        else if (b_inf)                               y = b;
        else if (sum == 28'd0)                        y = {~eff_sub & a[31], 31'd0};
        else if (res >= 32'h7F80_0000)                y = {big[31], 8'hFF, 23'd0};
        else                                          y = {big[31], res[30:0]};
    end
endmodule

module accf #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               busy
`ifdef ACCF_OVF_EN
    ,
    output logic               out_ovf
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} state_t;

    state_t              state;
    logic [32:0]         mem [DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                full, empty, push, pop, head_last;
    logic [31:0]         head_data, sum, add_y;
    logic [COUNT_W-1:0]  count;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = !full;
    assign push      = in_valid & !full;
    // HOLD blocks pops so a term of the next packet waits until IDLE
    assign pop       = !empty && (state != HOLD);
    assign {head_last, head_data} = mem[rd_ptr[AW-1:0]];

    assign out_data  = sum;
    assign out_count = count;
    assign busy      = (state != IDLE) || !empty;

    addf u_addf (
        .a (sum),
        .b (head_data),
        .y (add_y)
    );

    // FIFO storage: {last, data} written at the tail
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
    end

    // FIFO pointers; the extra MSB tells full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Accumulation FSM: load first term, add the rest, hold result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sum       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        sum       <= head_data;
                        count     <= COUNT_W'(1);
                        state     <= head_last ? HOLD : ACC;
                        out_valid <= head_last;
                    end
                end
                ACC: begin
                    if (pop) begin
                        sum       <= add_y;
                        count     <= count + COUNT_W'(1);
                        state     <= head_last ? HOLD : ACC;
                        out_valid <= head_last;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        sum       <= '0;
                        count     <= '0;
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ACCF_OVF_EN
    logic ovf;

    // Sticky flag: any value written to sum had an all-ones exponent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == HOLD) begin
            if (out_ready) ovf <= 1'b0;
        end else if (pop) begin
            ovf <= ovf | ((state == IDLE) ? (&head_data[30:23]) : (&add_y[30:23]));
        end
    end

    assign out_ovf = ovf;
`endif
endmodule

// File: tb/tb_accf.sv
// tb_accf: directed and randomized checks of accf against a packet-level
// floating-point reference model. Define ACCF_OVF_EN to also cover out_ovf.
module tb_accf;
  localparam int DEPTH   = 4;
  localparam int COUNT_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        in_data = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [31:0]        out_data;
  logic [COUNT_W-1:0] out_count;
  logic               busy;
`ifdef ACCF_OVF_EN
  logic               out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Expected packet results: {15'0, ovf, count[15:0], sum[31:0]}
  logic [63:0] exp_q[$];
  logic [31:0] pkt_terms[$];

  accf #(.DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
`ifdef ACCF_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic real f2r(input logic [31:0] f);
    real m;
    if (f[30:23] == 8'd0) m = real'(f[22:0]) * (2.0 ** (-149.0));
    else m = (real'(f[22:0]) + 8388608.0) * (2.0 ** real'(int'(f[30:23]) - 150));
    return f[31] ? -m : m;
  endfunction

  // Round a double to binary32, nearest-even (the double sum of two floats
  // is exact or correctly rounded with enough spare bits for this)
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] rb, sig, kept, rem, half, bits;
    int e, sh;
    rb = $realtobits(r);
    if (rb[62:0] == 63'd0) return {rb[63], 31'd0};
    e   = int'(rb[62:52]) - 1023;
    sig = {11'd0, 1'b1, rb[51:0]};
    sh  = (e >= -126) ? 29 : 29 + (-126 - e);
    if (sh > 60) sh = 60;
    kept = sig >> sh;
    rem  = sig & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
    if (e >= -126) bits = (64'(e + 126) << 23) + kept;
    else bits = kept;
    if (bits >= 64'h7F80_0000) bits = 64'h7F80_0000;
    return {rb[63], bits[30:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    bit a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) return 32'h7FC0_0000;
    if (a_inf) return a;
    if (b_inf) return b;
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Fold the finished packet into one expected result
  task automatic model_close_packet();
    logic [31:0] s;
    bit ovf;
    s   = pkt_terms[0];
    ovf = (s[30:23] == 8'hFF);
    for (int i = 1; i < pkt_terms.size(); i++) begin
      s   = ref_add(s, pkt_terms[i]);
      ovf = ovf | (s[30:23] == 8'hFF);
    end
    exp_q.push_back({15'd0, ovf, 16'(pkt_terms.size()), s});
    pkt_terms.delete();
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic push(input logic [31:0] d, input bit l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    pkt_terms.push_back(d);
    if (l) model_close_packet();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_valid", tag), out_valid, 1);
  endtask

  // Hold out_ready low for some cycles checking stability, then take result
  task automatic take(input string tag, input int hold_cycles);
    logic [63:0] e;
    e = '0;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_expected_avail observed=0 expected=1", tag);
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    for (int i = 0; i < hold_cycles; i++) begin
      check($sformatf("%s_hold_data", tag), out_data, e[31:0]);
      @(negedge clk);
    end
    check($sformatf("%s_valid_at_take", tag), out_valid, 1);
    check($sformatf("%s_data", tag), out_data, e[31:0]);
    check($sformatf("%s_count", tag), out_count, e[47:32]);
`ifdef ACCF_OVF_EN
    check($sformatf("%s_ovf", tag), out_ovf, e[48]);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s_valid_after_take", tag), out_valid, 0);
  endtask

  function automatic logic [31:0] gen_term();
    logic [7:0] e;
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) e = 8'($urandom_range(250, 254));
    else               e = 8'($urandom_range(118, 136));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int len;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_busy", busy, 0);
`ifdef ACCF_OVF_EN
    check("rst_ovf", out_ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 1.0 + 5.0, result one cycle after the last push
    push(32'h3F80_0000, 1'b0);
    push(32'h40A0_0000, 1'b1);
    check("t1_valid_early", out_valid, 0);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_valid_latency", out_valid, 1);
    check("t1_data_const", out_data, 32'h40C0_0000);
    check("t1_count_const", out_count, 2);
    take("t1", 0);

    // three terms with a stalled consumer, FIFO fills behind HOLD
    push(32'h3F80_0000, 1'b0);
    push(32'h40A0_0000, 1'b0);
    push(32'h428A_0000, 1'b1);
    wait_valid("t2", 10);
    check("t2_data_const", out_data, 32'h4296_0000);
    check("t2_count_const", out_count, 3);
    for (int i = 0; i < DEPTH; i++) push(32'h3F80_0000, i == DEPTH - 1);
    check("t2_full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 32'h4120_0000;
    in_last  = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_full_ready_held", in_ready, 0);
    in_valid = 1'b0;
    take("t2", 5);
    wait_valid("t2b", 20);
    check("t2b_data_const", out_data, 32'h4080_0000);
    take("t2b", 1);

    // single-term packet is loaded directly
    push(32'h404C_CCCD, 1'b1);
    wait_valid("t3", 10);
    check("t3_data_const", out_data, 32'h404C_CCCD);
    take("t3", 0);

    // back-to-back packets cost one idle cycle after the handshake
    push(32'h4000_0000, 1'b0);
    push(32'hC000_0000, 1'b1);
    push(32'h40A0_0000, 1'b1);
    wait_valid("t4", 10);
    check("t4_zero_mag", out_data[30:0], 0);
    take("t4", 1);
    @(negedge clk);
    check("t4b_valid_latency", out_valid, 1);
    check("t4b_data_const", out_data, 32'h40A0_0000);
    take("t4b", 0);

    // reset mid-packet
    push(32'h3F80_0000, 1'b0);
    push(32'h4000_0000, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready", in_ready, 1);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_count", out_count, 0);
    pkt_terms.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(32'h40A0_0000, 1'b1);
    wait_valid("t5", 10);
    check("t5_data_const", out_data, 32'h40A0_0000);
    take("t5", 0);

`ifdef ACCF_OVF_EN
    // overflow to infinity raises out_ovf, cleared by the handshake
    push(32'h7F7F_FFFF, 1'b0);
    push(32'h7F7F_FFFF, 1'b1);
    wait_valid("t6", 10);
    check("t6_ovf_const", out_ovf, 1);
    take("t6", 0);
    push(32'h3F80_0000, 1'b1);
    wait_valid("t6b", 10);
    check("t6b_ovf_const", out_ovf, 0);
    take("t6b", 0);
`endif

    // randomized packets with input gaps and consumer stalls
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        push(gen_term(), j == len - 1);
      end
      wait_valid($sformatf("rnd%0d", p), 20);
      take($sformatf("rnd%0d", p), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("end_busy", busy, 0);
    check("end_queue_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/accf.md
# accf

Streaming single-precision accumulator wrapped around the combinational `addf` adder. It accepts a packet of IEEE-754 binary32 terms over a valid/ready handshake and buffers them in a small FIFO. Terms are summed in arrival order, one per cycle, by feeding `addf` with the running sum and the FIFO head. The packet total is presented on a valid/ready output port. It sits directly upstream of `addf` (operand sequencing) and downstream of it (result capture), so software-style reductions can use the single-cycle adder.

## Interface
- `DEPTH`, 4: input FIFO entries, power of two, ≥2.
- `COUNT_W`, 16: width of the term counter.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: term offered.
- `in_ready` output 1: FIFO can accept a term.
- `in_data` input 32: binary32 term.
- `in_last` input 1: term is the final term of its packet.
- `out_valid` output 1: packet sum available.
- `out_ready` input 1: consumer takes the sum.
- `out_data` output 32: binary32 packet sum.
- `out_count` output COUNT_W: number of terms in the summed packet (wraps mod 2^COUNT_W).
- `busy` output 1: state ≠ IDLE or FIFO non-empty.
- `out_ovf` output 1: present only with `ACCF_OVF_EN` (see Configuration).

## Operation
- FIFO stores {in_last, in_data}.
  - Push on `in_valid & in_ready`.
  - `in_ready = !full`, registered-state based. There is no bypass: a full FIFO refuses a push even in a cycle that pops.
- Pop condition: FIFO non-empty and state ∈ {IDLE, ACC}. One pop per cycle maximum.
- States:
  - IDLE: sum=0, count=0. On pop: sum ← head (loaded directly, not via `addf`), count ← 1. Next state is HOLD if the head's last flag is set, else ACC.
  - ACC: on pop: sum ← `addf(sum, head)`, count ← count+1. Next state is HOLD if the head's last flag is set, else stay in ACC. With no pop, hold everything.
  - HOLD: `out_valid`=1, `out_data`=sum, `out_count`=count. No pops; the FIFO may still fill. On `out_ready`: sum ← 0, count ← 0, state ← IDLE.
- `out_data`/`out_count` are valid only while `out_valid`=1. Both hold stable until the handshake completes.
- Arithmetic: rounding, sign, special values and zero handling are exactly those of `addf`. The block adds no normalisation of its own.
- Packets never merge. A term pushed while in HOLD stays in the FIFO until IDLE.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_count`=0, `busy`=0, `out_ovf`=0. State=IDLE and FIFO empty.
- Term accepted at edge k into an empty FIFO is popped at edge k+1.
- A last term accepted at edge k with the FIFO otherwise empty and the state not HOLD gives `out_valid`=1 after edge k+1.
- Sustained throughput: one term per cycle. Back-to-back packets cost one extra cycle: the HOLD→IDLE handshake edge does not pop.
- Reset asserted mid-packet: the FIFO is flushed, the partial sum is discarded, and all outputs return to reset values asynchronously.
- `out_ready` outside HOLD has no effect. `in_valid` while full: the term is not taken and the source must hold it.

## Configuration
- `ACCF_OVF_EN` defined:
  - `out_ovf` port exists.
  - `out_ovf` is a sticky flag, set when any `addf` result written to sum, or any directly loaded first term, has exponent 8'hFF.
  - Cleared on the HOLD→IDLE handshake. Valid alongside `out_valid`.
- `ACCF_OVF_EN` undefined: the port and its logic are absent. Sums are otherwise identical.

## Test plan
- Packet {0x3F800000 (1.0), 0x40A00000 last (5.0)} pushed on consecutive cycles → `out_data`=0x40C00000, `out_count`=2, `out_valid` one cycle after the last push.
- Packet {0x3F800000, 0x40A00000, 0x428A0000 last (69.0)} with `out_ready` held 0 for 5 cycles → `out_data`=0x42960000 (75.0) stable throughout, `out_count`=3. Further pushes fill the FIFO to DEPTH and then `in_ready`=0.
- Single-term packet 0x404CCCCD last (3.2) → `out_data`=0x404CCCCD, `out_count`=1, no `addf` involvement.
- Two back-to-back packets {0x40000000 (2.0), 0xC0000000 last (-2.0)} and {0x40A00000 last} → first sum has magnitude bits 0 (0x00000000 or 0x80000000 per `addf`). The second packet sum is 0x40A00000, presented after the first handshake plus one idle cycle.
- Reset pulsed after two of four terms are accepted → `out_valid`=0, `busy`=0, `in_ready`=1. A fresh packet {0x40A00000 last} then yields 0x40A00000, count 1.
- `ACCF_OVF_EN`: packet {0x7F7FFFFF, 0x7F7FFFFF last} → `out_ovf`=1 with `out_valid`. After the handshake, packet {0x3F800000 last} → `out_ovf`=0.
